controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, sets the width of every internal phase counter; all phase lengths SHALL fit in ADDR_WIDTH bits.
REQ-002 Parameters INIT_LEN=24, VPU_LEN=24, CPU_LEN=4, MAX_ITER=8, WR_LAT=2 SHALL set the phase lengths, iteration count and write-back latency.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-high (asserted at 1 despite the name).
REQ-005 ini_st  input  1  decode start request, sampled in IDLE only.
REQ-006 initial_on  output  1  high while in INIT.
REQ-007 vpu_on  output  1  high while in VPU.
REQ-008 cpu_on  output  1  high while in CPU.
REQ-009 vpu_rd_addr_en  output  1  advances the VPU read address.
REQ-010 vpu_wr_addr_en  output  1  advances the VPU write address.
REQ-011 cpu_wr_addr_en  output  1  advances the CPU write address.
REQ-012 llr_ram_rden  output  1  LLR RAM read enable.
REQ-013 llr_ram_wren  output  1  LLR RAM write enable.
REQ-014 in_info_rden  output  1  input-info buffer read enable.

Function
REQ-015 States SHALL be IDLE, INIT, VPU and CPU, with one phase counter (cnt) and one iteration counter (iter); all outputs SHALL be registered.
REQ-016 IDLE: all outputs 0; ini_st=1 -> INIT at the next edge with cnt=0 and iter=0; ini_st SHALL be ignored in every other state.
REQ-017 INIT SHALL last INIT_LEN+RL cycles (RL=1, see REQ-027); in_info_rden=1 for cnt 0..INIT_LEN-1; llr_ram_wren=1 for cnt RL..INIT_LEN+RL-1; exit -> VPU with cnt=0.
REQ-018 VPU SHALL last VPU_LEN+WR_LAT cycles; vpu_rd_addr_en=llr_ram_rden=1 for cnt 0..VPU_LEN-1; vpu_wr_addr_en=1 for cnt WR_LAT..VPU_LEN+WR_LAT-1; exit -> CPU with cnt=0.
REQ-019 CPU SHALL last CPU_LEN+WR_LAT cycles; cpu_wr_addr_en=1 for cnt WR_LAT..CPU_LEN+WR_LAT-1.
REQ-020 At CPU exit: if iter==MAX_ITER-1 -> IDLE; otherwise iter increments -> VPU with cnt=0.
REQ-021 Exactly one of initial_on, vpu_on and cpu_on SHALL be high outside IDLE; none SHALL be high in IDLE.
REQ-022 ini_st held high through the final CPU cycle SHALL start a new decode from IDLE one cycle later (IDLE held for one cycle minimum).
REQ-023 cnt SHALL reset to 0 on every state change and SHALL never wrap within a phase.

Reset
REQ-024 rst_n=1 at a clock edge SHALL force IDLE, cnt=0, iter=0 and all outputs 0 by the next edge, including mid-phase.
REQ-025 While rst_n=1, ini_st SHALL be ignored; the first start SHALL be accepted on the first edge with rst_n=0.

Configuration
REQ-026 Macro CTRL_REG_RAM_EN SHALL model a registered-output LLR/input RAM.
REQ-027 Without CTRL_REG_RAM_EN, RL=1; with CTRL_REG_RAM_EN, RL=2, so INIT lasts INIT_LEN+2 cycles and llr_ram_wren lags in_info_rden by 2 cycles; all other timing SHALL be unchanged.

Verification
REQ-028 Defaults, no macro, ini_st=1 for cycle 0 -> initial_on cycles 1..25, in_info_rden 1..24, llr_ram_wren 2..25.
REQ-029 Same run -> vpu_on 26..51, vpu_rd_addr_en/llr_ram_rden 26..49, vpu_wr_addr_en 28..51, cpu_on 52..57, cpu_wr_addr_en 54..57, second vpu_on from 58.
REQ-030 Same run -> 8 iterations, last cpu_on cycle 281, all outputs 0 from cycle 282, ini_st pulses ignored during cycles 1..281.
REQ-031 rst_n=1 at cycle 40 (mid-VPU) -> all outputs 0 from cycle 41; ini_st at cycle 50 after rst_n=0 -> initial_on from cycle 51.
REQ-032 CTRL_REG_RAM_EN defined -> llr_ram_wren cycles 3..26, initial_on 1..26, vpu_on from cycle 27.

Source files
------------

// File: rtl/controller.sv
`default_nettype none
// ============================================================================
//  Module   : controller
//  Purpose  : Sequencer for an iterative LLR decoder. After a start request
//             it runs one INIT phase (input buffer -> LLR RAM copy), then
//             MAX_ITER rounds of a VPU phase followed by a CPU phase, and
//             then returns to IDLE. Each phase drives the read/write enables
//             of the memories and address generators around it.
//
//  Ports    : clk            - single clock, rising edge
//             rst_n          - synchronous reset, ACTIVE-HIGH despite its name
//             ini_st         - start request, only honoured in IDLE
//             initial_on     - high during INIT
//             vpu_on         - high during VPU
//             cpu_on         - high during CPU
//             vpu_rd_addr_en - advance VPU read address
//             vpu_wr_addr_en - advance VPU write address
//             cpu_wr_addr_en - advance CPU write address
//             llr_ram_rden   - LLR RAM read enable
//             llr_ram_wren   - LLR RAM write enable
//             in_info_rden   - input-info buffer read enable
//
//  Options  : CTRL_REG_RAM_EN - the input/LLR RAMs have registered outputs,
//             so the read latency is 2 instead of 1. INIT is one cycle longer
//             and llr_ram_wren lags in_info_rden by 2 cycles.
//
//  Revision : 1.0 - initial release
// ============================================================================
module controller #(
    parameter int ADDR_WIDTH = 8,
    parameter int INIT_LEN   = 24,
    parameter int VPU_LEN    = 24,
    parameter int CPU_LEN    = 4,
    parameter int MAX_ITER   = 8,
    parameter int WR_LAT     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ini_st,
    output logic initial_on,
    output logic vpu_on,
    output logic cpu_on,
    output logic vpu_rd_addr_en,
    output logic vpu_wr_addr_en,
    output logic cpu_wr_addr_en,
    output logic llr_ram_rden,
    output logic llr_ram_wren,
    output logic in_info_rden
);

    // Read latency of the buffer feeding the LLR RAM during INIT.
`ifdef CTRL_REG_RAM_EN
    localparam int c_rl = 2;
`else
    localparam int c_rl = 1;
`endif

    localparam logic [ADDR_WIDTH-1:0] c_init_last = ADDR_WIDTH'(INIT_LEN + c_rl - 1);
    localparam logic [ADDR_WIDTH-1:0] c_vpu_last  = ADDR_WIDTH'(VPU_LEN + WR_LAT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_cpu_last  = ADDR_WIDTH'(CPU_LEN + WR_LAT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_iter_last = ADDR_WIDTH'(MAX_ITER - 1);
    localparam logic [ADDR_WIDTH-1:0] c_init_len  = ADDR_WIDTH'(INIT_LEN);
    localparam logic [ADDR_WIDTH-1:0] c_vpu_len   = ADDR_WIDTH'(VPU_LEN);
    localparam logic [ADDR_WIDTH-1:0] c_wr_lat    = ADDR_WIDTH'(WR_LAT);
    localparam logic [ADDR_WIDTH-1:0] c_rl_w      = ADDR_WIDTH'(c_rl);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_VPU  = 2'd2,
        ST_CPU  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   r_iter;

    state_t                  w_nxt_state;
    logic [ADDR_WIDTH-1:0]   w_nxt_cnt;
    logic [ADDR_WIDTH-1:0]   w_nxt_iter;

    // Next-state view of the sequencer. The outputs are registered from
    // these next values so that each output flop is valid in the very
    // cycle the state/count it describes becomes current.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + 1'b1;
        w_nxt_iter  = r_iter;
        case (r_state)
            ST_IDLE: begin
                w_nxt_cnt  = '0;
                w_nxt_iter = '0;
                if (ini_st) begin
                    w_nxt_state = ST_INIT;
                end
            end
            ST_INIT: begin
                if (r_cnt == c_init_last) begin
                    w_nxt_state = ST_VPU;
                    w_nxt_cnt   = '0;
                end
            end
            ST_VPU: begin
                if (r_cnt == c_vpu_last) begin
                    w_nxt_state = ST_CPU;
                    w_nxt_cnt   = '0;
                end
            end
            ST_CPU: begin
                if (r_cnt == c_cpu_last) begin
                    w_nxt_cnt = '0;
                    if (r_iter == c_iter_last) begin
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_state = ST_VPU;
                        w_nxt_iter  = r_iter + 1'b1;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = '0;
                w_nxt_iter  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_iter         <= '0;
            initial_on     <= 1'b0;
            vpu_on         <= 1'b0;
            cpu_on         <= 1'b0;
            vpu_rd_addr_en <= 1'b0;
            vpu_wr_addr_en <= 1'b0;
            cpu_wr_addr_en <= 1'b0;
            llr_ram_rden   <= 1'b0;
            llr_ram_wren   <= 1'b0;
            in_info_rden   <= 1'b0;
        end else begin
            r_state        <= w_nxt_state;
            r_cnt          <= w_nxt_cnt;
            r_iter         <= w_nxt_iter;
            initial_on     <= (w_nxt_state == ST_INIT);
            vpu_on         <= (w_nxt_state == ST_VPU);
            cpu_on         <= (w_nxt_state == ST_CPU);
            // INIT: read the input buffer for INIT_LEN cycles; the LLR RAM
            // write trails it by the buffer read latency.
            in_info_rden   <= (w_nxt_state == ST_INIT) && (w_nxt_cnt < c_init_len);
            llr_ram_wren   <= (w_nxt_state == ST_INIT) && (w_nxt_cnt >= c_rl_w);
            // VPU: reads for VPU_LEN cycles, write-back trails by WR_LAT.
            vpu_rd_addr_en <= (w_nxt_state == ST_VPU) && (w_nxt_cnt < c_vpu_len);
            llr_ram_rden   <= (w_nxt_state == ST_VPU) && (w_nxt_cnt < c_vpu_len);
            vpu_wr_addr_en <= (w_nxt_state == ST_VPU) && (w_nxt_cnt >= c_wr_lat);
            cpu_wr_addr_en <= (w_nxt_state == ST_CPU) && (w_nxt_cnt >= c_wr_lat);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controller
//  Purpose  : Self-checking bench for controller. Directed runs with
//             expected output patterns computed from the phase timing:
//             reset hold with a pending start, one full decode with stray
//             start pulses, back-to-back decodes with start held high, and
//             a mid-VPU reset followed by a restart.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_controller;

    localparam int INIT_LEN = 24;
    localparam int VPU_LEN  = 24;
    localparam int CPU_LEN  = 4;
    localparam int MAX_ITER = 8;
    localparam int WR_LAT   = 2;
`ifdef CTRL_REG_RAM_EN
    localparam int RL = 2;
`else
    localparam int RL = 1;
`endif
    localparam int IL = INIT_LEN + RL;           // INIT length (25 by default)
    localparam int VL = VPU_LEN + WR_LAT;        // 26
    localparam int CL = CPU_LEN + WR_LAT;        // 6
    // Cycles from one accepted start to the next when start is held high:
    // start cycle + INIT + 8*(VPU+CPU) = 1 + 25 + 256 = 282.
    localparam int PERIOD = 1 + IL + MAX_ITER * (VL + CL);

    logic clk;
    logic rst_n;
    logic ini_st;
    logic initial_on, vpu_on, cpu_on;
    logic vpu_rd_addr_en, vpu_wr_addr_en, cpu_wr_addr_en;
    logic llr_ram_rden, llr_ram_wren, in_info_rden;

    int n_err;
    int n_chk;

    controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ini_st         (ini_st),
        .initial_on     (initial_on),
        .vpu_on         (vpu_on),
        .cpu_on         (cpu_on),
        .vpu_rd_addr_en (vpu_rd_addr_en),
        .vpu_wr_addr_en (vpu_wr_addr_en),
        .cpu_wr_addr_en (cpu_wr_addr_en),
        .llr_ram_rden   (llr_ram_rden),
        .llr_ram_wren   (llr_ram_wren),
        .in_info_rden   (in_info_rden)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: initial_on vpu_on cpu_on vpu_rd vpu_wr cpu_wr rden wren info
    function automatic logic [8:0] obs();
        return {initial_on, vpu_on, cpu_on, vpu_rd_addr_en, vpu_wr_addr_en,
                cpu_wr_addr_en, llr_ram_rden, llr_ram_wren, in_info_rden};
    endfunction

    // Expected outputs t cycles after the cycle in which a start was sampled.
    function automatic logic [8:0] expect_at(int t);
        int k, u, r, q;
        if (t < 1 || t >= PERIOD) return 9'b0;
        k = t - 1;
        if (k < IL)
            return {1'b1, 5'b0, 1'b0, (k >= RL), (k < INIT_LEN)};
        u = k - IL;
        r = u % (VL + CL);
        if (r < VL)
            return {1'b0, 1'b1, 1'b0, (r < VPU_LEN), (r >= WR_LAT), 1'b0,
                    (r < VPU_LEN), 2'b0};
        q = r - VL;
        return {2'b0, 1'b1, 2'b0, (q >= WR_LAT), 3'b0};
    endfunction

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    // Drive one cycle's inputs (we are just past a rising edge), check the
    // outputs mid-cycle, then advance to just past the next rising edge.
    task automatic cycle_chk(input logic rst_v, input logic ini_v,
                             input logic [8:0] want, input string tag);
        rst_n  = rst_v;
        ini_st = ini_v;
        @(negedge clk);
        check_eq(tag, obs(), want);
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_nochk(input logic rst_v, input logic ini_v);
        rst_n  = rst_v;
        ini_st = ini_v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_err  = 0;
        n_chk  = 0;
        rst_n  = 1'b1;
        ini_st = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with a start pending: must stay idle.
        for (int c = 0; c < 3; c++)
            cycle_chk(1'b1, 1'b1, 9'b0, $sformatf("rst_hold c%0d", c));

        // Single decode started in cycle 0 (first cycle out of reset), with
        // stray start pulses inside the run that must be ignored.
        for (int c = 0; c < 300; c++) begin
            logic s;
            s = (c == 0) || (c == 10) || (c == 30) || (c == 55) ||
                (c == 150) || (c == PERIOD - 1);
            cycle_chk(1'b0, s, expect_at(c), $sformatf("run1 c%0d", c));
        end

        // Start held high: one IDLE cycle between consecutive decodes.
        for (int c = 0; c < 400; c++)
            cycle_chk(1'b0, 1'b1, expect_at(c % PERIOD), $sformatf("run2 c%0d", c));

        // Clean up the run still in progress before the reset scenario.
        cycle_nochk(1'b1, 1'b0);
        cycle_chk(1'b1, 1'b0, 9'b0, "rst_clean");

        // Reset mid-VPU at cycle 40 (start request ignored), restart at 50.
        for (int c = 0; c < 90; c++) begin
            logic       r, s;
            logic [8:0] w;
            r = (c == 40);
            s = (c == 0) || (c == 40) || (c == 50);
            w = (c <= 40) ? expect_at(c) : expect_at(c - 50);
            cycle_chk(r, s, w, $sformatf("run3 c%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
